// File: rtl/pixfetch_pkg.sv
// pixfetch_pkg
// Shared constants, FSM state type and the map address helper for the
// pixel fetch arbiter. Optional build macro: PIXFETCH_HFLIP_EN (see
// pixfetch_addr_gen).
package pixfetch_pkg;

    localparam int MAP_W      = 320;
    localparam int MAP_DEPTH  = 76800;
    localparam int SPR_W      = 16;
    localparam int SPR_H      = 16;
    localparam int CHAR_DEPTH = 6613;
    localparam int STARVE_MAX = 15;

    localparam int MAP_AW     = 19;
    localparam int CHAR_AW    = 13;
    localparam int PIX_W      = 8;
    localparam int COORD_W    = 9;
    localparam int FRAME_W    = 5;
    localparam int DIFF_W     = 10;
    localparam int CADDR_W    = 14;
    localparam int SPR_XB     = $clog2(SPR_W);
    localparam int SPR_YB     = $clog2(SPR_H);
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    localparam logic [PIX_W-1:0] TRANS_KEY = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } fsm_state_t;

    // Linear map RAM address for a map-space coordinate, row-major.
    function automatic logic [MAP_AW-1:0] map_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return MAP_AW'(y) * MAP_AW'(MAP_W) + MAP_AW'(x);
    endfunction

endpackage

// File: rtl/pixfetch_addr_gen.sv
// pixfetch_addr_gen
// Combinational sprite hit test plus map / char RAM read addresses and
// their bounds flags. With PIXFETCH_HFLIP_EN defined, a set spr_hflip
// mirrors the sprite column; otherwise spr_hflip is ignored.
module pixfetch_addr_gen import pixfetch_pkg::*; (
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [FRAME_W-1:0] spr_frame,
    input  logic               spr_hflip,
    output logic [MAP_AW-1:0]  map_rd_addr,
    output logic               map_oob,
    output logic [CHAR_AW-1:0] char_rd_addr,
    output logic               spr_hit
);

    logic [DIFF_W-1:0]  dx;
    logic [DIFF_W-1:0]  dy;
    logic               in_box;
    logic [SPR_XB-1:0]  col;
    logic [CADDR_W-1:0] char_lin;
    logic               char_oob;
    logic [MAP_AW-1:0]  map_lin;

    // Pixel offset inside the sprite box; the ordering tests reject wrapped offsets.
    always_comb begin
        dx     = DIFF_W'(pix_x) - DIFF_W'(spr_x);
        dy     = DIFF_W'(pix_y) - DIFF_W'(spr_y);
        in_box = (pix_x >= spr_x) && (pix_y >= spr_y) &&
                 (dx < DIFF_W'(SPR_W)) && (dy < DIFF_W'(SPR_H));
    end

`ifdef PIXFETCH_HFLIP_EN
    // Mirrored sprites read their columns counting in from the right edge.
    always_comb begin
        col = spr_hflip ? (SPR_XB'(SPR_W - 1) - dx[SPR_XB-1:0]) : dx[SPR_XB-1:0];
    end
`else
    logic unused_hflip;

    // Flip support is compiled out, so the column is the raw offset.
    always_comb begin
        col          = dx[SPR_XB-1:0];
        unused_hflip = spr_hflip;
    end
`endif

    // Char RAM address; anything past the end of the RAM counts as a miss and reads address 0.
    always_comb begin
        char_lin     = CADDR_W'(spr_frame) * CADDR_W'(SPR_W * SPR_H) +
                       CADDR_W'(dy[SPR_YB-1:0]) * CADDR_W'(SPR_W) + CADDR_W'(col);
        char_oob     = (char_lin >= CADDR_W'(CHAR_DEPTH));
        spr_hit      = in_box && !char_oob;
        char_rd_addr = spr_hit ? char_lin[CHAR_AW-1:0] : '0;
    end

    // Map RAM address; off-map coordinates read address 0 and are flagged so the pixel is blanked.
    always_comb begin
        map_lin     = map_addr(pix_x, pix_y);
        map_oob     = (map_lin >= MAP_AW'(MAP_DEPTH));
        map_rd_addr = map_oob ? '0 : map_lin;
    end

endmodule

// File: rtl/pixel_fetch_arbiter.sv
// pixel_fetch_arbiter
// Fetches one map pixel and one sprite pixel per request, composites the
// sprite over the map and returns a palette index. Shares the RAM write
// ports with the asset loader, with a starvation guard for writes.
// Optional build macro: PIXFETCH_HFLIP_EN (horizontal sprite mirroring).
module pixel_fetch_arbiter import pixfetch_pkg::*; (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [FRAME_W-1:0] spr_frame,
    input  logic               spr_hflip,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_pix,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_sel,
    input  logic [MAP_AW-1:0]  wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    output logic               map_we,
    output logic [MAP_AW-1:0]  map_wr_addr,
    output logic [MAP_AW-1:0]  map_rd_addr,
    output logic [PIX_W-1:0]   map_din,
    input  logic [PIX_W-1:0]   map_dout,
    output logic               char_we,
    output logic [CHAR_AW-1:0] char_wr_addr,
    output logic [CHAR_AW-1:0] char_rd_addr,
    output logic [PIX_W-1:0]   char_din,
    input  logic [PIX_W-1:0]   char_dout
);

    fsm_state_t            state;
    logic                  in_idle;
    logic [COORD_W-1:0]    req_pix_x;
    logic [COORD_W-1:0]    req_pix_y;
    logic [COORD_W-1:0]    req_spr_x;
    logic [COORD_W-1:0]    req_spr_y;
    logic [FRAME_W-1:0]    req_frame;
    logic                  req_hflip;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  starve_full;
    logic                  accept;
    logic                  wr_grant;
    logic                  map_oob;
    logic                  spr_hit;

    pixfetch_addr_gen u_addr_gen (
        .pix_x        (req_pix_x),
        .pix_y        (req_pix_y),
        .spr_x        (req_spr_x),
        .spr_y        (req_spr_y),
        .spr_frame    (req_frame),
        .spr_hflip    (req_hflip),
        .map_rd_addr  (map_rd_addr),
        .map_oob      (map_oob),
        .char_rd_addr (char_rd_addr),
        .spr_hit      (spr_hit)
    );

    // A saturated starvation count lets a pending write pre-empt the next read.
    assign starve_full = (starve_cnt == STARVE_W'(STARVE_MAX));
    assign wr_ready    = in_idle && (!pix_valid || starve_full);
    assign pix_ready   = in_idle && !(starve_full && wr_valid);
    assign accept      = pix_valid && pix_ready;
    assign wr_grant    = wr_valid && wr_ready;

    assign map_we       = wr_grant && !wr_sel;
    assign char_we      = wr_grant && wr_sel;
    assign map_wr_addr  = wr_addr;
    assign char_wr_addr = wr_addr[CHAR_AW-1:0];
    assign map_din      = wr_data;
    assign char_din     = wr_data;

    // Request sequencer: latch request, present addresses, compose after the RAM latency, hold until taken.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            in_idle   <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            req_pix_x <= '0;
            req_pix_y <= '0;
            req_spr_x <= '0;
            req_spr_y <= '0;
            req_frame <= '0;
            req_hflip <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_idle <= 1'b1;
                    if (accept) begin
                        req_pix_x <= pix_x;
                        req_pix_y <= pix_y;
                        req_spr_x <= spr_x;
                        req_spr_y <= spr_y;
                        req_frame <= spr_frame;
                        req_hflip <= spr_hflip;
                        in_idle   <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (map_oob) begin
                        out_pix <= '0;
                    end else if (spr_hit && (char_dout != TRANS_KEY)) begin
                        out_pix <= char_dout;
                    end else begin
                        out_pix <= map_dout;
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_idle   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_idle   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Count cycles a write has been refused; saturates and clears once the write is granted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= '0;
        end else if (wr_grant) begin
            starve_cnt <= '0;
        end else if (wr_valid && !starve_full) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_fetch_arbiter.sv
// tb_pixel_fetch_arbiter
// Table-driven directed vectors, hand-written multi-cycle sequences and a
// randomized run checked against a coordinate-level reference model.
// Honours PIXFETCH_HFLIP_EN when the design is built with it.
module tb_pixel_fetch_arbiter;

    localparam int MAPW   = 320;
    localparam int MAPD   = 76800;
    localparam int CHARD  = 6613;
    localparam int SPRW   = 16;
    localparam int SPRH   = 16;
`ifdef PIXFETCH_HFLIP_EN
    localparam bit HFLIP_EN = 1'b1;
`else
    localparam bit HFLIP_EN = 1'b0;
`endif

    typedef struct {
        int px; int py; int sx; int sy; int frame;
        int ld_map_a; int ld_map_v; int ld_char_a; int ld_char_v;
        int exp_pix; int exp_map; int exp_char;
    } vec_t;

    logic        Clk;
    logic        Reset_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_x, pix_y, spr_x, spr_y;
    logic [4:0]  spr_frame;
    logic        spr_hflip;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_sel;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        map_we;
    logic [18:0] map_wr_addr, map_rd_addr;
    logic [7:0]  map_din, map_dout;
    logic        char_we;
    logic [12:0] char_wr_addr, char_rd_addr;
    logic [7:0]  char_din, char_dout;

    logic [7:0]  map_mem  [0:MAPD-1];
    logic [7:0]  char_mem [0:CHARD-1];

    int n_checks = 0;
    int n_errors = 0;

    pixel_fetch_arbiter dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_frame    (spr_frame),
        .spr_hflip    (spr_hflip),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pix      (out_pix),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .map_we       (map_we),
        .map_wr_addr  (map_wr_addr),
        .map_rd_addr  (map_rd_addr),
        .map_din      (map_din),
        .map_dout     (map_dout),
        .char_we      (char_we),
        .char_wr_addr (char_wr_addr),
        .char_rd_addr (char_rd_addr),
        .char_din     (char_din),
        .char_dout    (char_dout)
    );

    // Free-running clock, 10 time units per cycle.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Registered-read RAM models; contents are only ever loaded by the main sequence.
    always @(posedge Clk) begin
        map_dout  <= map_mem[map_rd_addr];
        char_dout <= char_mem[char_rd_addr];
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: map index for a coordinate, 0 when off the map.
    function automatic int ref_map_addr(input int px, input int py);
        int a;
        a = py * MAPW + px;
        return (a < MAPD) ? a : 0;
    endfunction

    // Reference model: char index of the sprite pixel under (px,py), -1 for a miss.
    function automatic int ref_char_idx(input int px, input int py, input int sx, input int sy,
                                        input int frame, input bit hflip);
        int col;
        int a;
        if (px < sx || py < sy || (px - sx) >= SPRW || (py - sy) >= SPRH) return -1;
        col = (HFLIP_EN && hflip) ? (SPRW - 1 - (px - sx)) : (px - sx);
        a = frame * SPRW * SPRH + (py - sy) * SPRW + col;
        return (a < CHARD) ? a : -1;
    endfunction

    // Reference model: composed palette index.
    function automatic int ref_pix(input int px, input int py, input int sx, input int sy,
                                   input int frame, input bit hflip);
        int ci;
        if (py * MAPW + px >= MAPD) return 0;
        ci = ref_char_idx(px, py, sx, sy, frame, hflip);
        if (ci >= 0 && char_mem[ci] != 8'h00) return int'(char_mem[ci]);
        return int'(map_mem[py * MAPW + px]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Present one request, wait for acceptance and the composed pixel; lat stays 99 on timeout.
    task automatic applyStimulus(input int px, input int py, input int sx, input int sy,
                                 input int frame, input bit hflip,
                                 output int got_pix, output int got_map,
                                 output int got_char, output int lat);
        int waitc;
        got_pix  = -1;
        got_map  = -1;
        got_char = -1;
        lat      = 99;
        @(negedge Clk);
        pix_x     = 9'(px);
        pix_y     = 9'(py);
        spr_x     = 9'(sx);
        spr_y     = 9'(sy);
        spr_frame = 5'(frame);
        spr_hflip = hflip;
        pix_valid = 1'b1;
        #1;
        waitc = 0;
        while (!pix_ready && waitc < 40) begin
            @(negedge Clk);
            #1;
            waitc++;
        end
        if (!pix_ready) begin
            pix_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) pix_valid = 1'b0;
            #1;
            if (k == 1) begin
                got_map  = int'(map_rd_addr);
                got_char = int'(char_rd_addr);
            end
            if (out_valid) begin
                lat     = k;
                got_pix = int'(out_pix);
                break;
            end
        end
    endtask

    vec_t vecs [11];

    initial begin
        int gp, gm, gc, gl;
        int grant_cyc, map_pulses, char_pulses, wa, wd, forced_rdy, sim_wr, sim_pix;
        int transfers, spurious, ok;
        int px, py, sx, sy, fr;
        bit hf;
        logic [31:0] r;

        vecs[0]  = '{0,   0,   100, 100, 0,  0,     'h3C, -1,   0,     'h3C, 0,     0};
        vecs[1]  = '{105, 103, 100, 100, 2,  33065, 'h11, 565,  'h7E,  'h7E, 33065, 565};
        vecs[2]  = '{105, 103, 100, 100, 2,  -1,    0,    565,  'h00,  'h11, 33065, 565};
        vecs[3]  = '{0,   240, 0,   240, 0,  -1,    0,    0,    'h99,  'h00, 0,     0};
        vecs[4]  = '{105, 113, 100, 100, 25, 36265, 'h22, -1,   0,     'h22, 36265, 0};
        vecs[5]  = '{104, 113, 100, 100, 25, 36264, 'h23, 6612, 'h44,  'h44, 36264, 6612};
        vecs[6]  = '{115, 100, 100, 100, 0,  32115, 'h66, 15,   'h5A,  'h5A, 32115, 15};
        vecs[7]  = '{116, 100, 100, 100, 0,  32116, 'h67, -1,   0,     'h67, 32116, 0};
        vecs[8]  = '{99,  100, 100, 100, 0,  32099, 'h68, -1,   0,     'h68, 32099, 0};
        vecs[9]  = '{319, 239, 0,   0,   0,  76799, 'h7F, -1,   0,     'h7F, 76799, 0};
        vecs[10] = '{100, 115, 100, 100, 1,  36900, 'h01, 496,  'hC3,  'hC3, 36900, 496};

        Reset_n = 1'b1;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; spr_x = '0; spr_y = '0;
        spr_frame = '0; spr_hflip = 1'b0; out_ready = 1'b1;
        wr_valid = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;

        for (int i = 0; i < MAPD; i++) map_mem[i] = 8'($urandom);
        for (int i = 0; i < CHARD; i++) begin
            r = $urandom;
            char_mem[i] = (r[1:0] == 2'b00) ? 8'h00 : r[15:8];
        end

        // Reset values
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_pix", int'(out_pix), 0);
        checkOutput("reset_pix_ready", int'(pix_ready), 0);
        checkOutput("reset_wr_ready", int'(wr_ready), 0);
        checkOutput("reset_we", int'(map_we | char_we), 0);
        checkOutput("reset_map_rd_addr", int'(map_rd_addr), 0);
        checkOutput("reset_char_rd_addr", int'(char_rd_addr), 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        #1 checkOutput("release_pix_ready_low", int'(pix_ready), 0);
        @(negedge Clk);
        #1 checkOutput("release_pix_ready_high", int'(pix_ready), 1);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].ld_map_a >= 0) map_mem[vecs[i].ld_map_a] = 8'(vecs[i].ld_map_v);
            if (vecs[i].ld_char_a >= 0) char_mem[vecs[i].ld_char_a] = 8'(vecs[i].ld_char_v);
            applyStimulus(vecs[i].px, vecs[i].py, vecs[i].sx, vecs[i].sy, vecs[i].frame, 1'b0,
                          gp, gm, gc, gl);
            checkOutput($sformatf("vec%0d_latency", i), gl, 3);
            checkOutput($sformatf("vec%0d_pix", i), gp, vecs[i].exp_pix);
            checkOutput($sformatf("vec%0d_map_addr", i), gm, vecs[i].exp_map);
            checkOutput($sformatf("vec%0d_char_addr", i), gc, vecs[i].exp_char);
        end

        // Horizontal flip request
        char_mem[565] = 8'h7E;
        char_mem[570] = 8'h3D;
        applyStimulus(105, 103, 100, 100, 2, 1'b1, gp, gm, gc, gl);
`ifdef PIXFETCH_HFLIP_EN
        checkOutput("hflip_char_addr", gc, 570);
        checkOutput("hflip_pix", gp, 'h3D);
`else
        checkOutput("hflip_ignored_char_addr", gc, 565);
        checkOutput("hflip_ignored_pix", gp, 'h7E);
`endif

        // Write while idle with no read pending
        @(negedge Clk);
        wr_valid = 1'b1; wr_sel = 1'b0; wr_addr = 19'd1234; wr_data = 8'h5C;
        #1;
        checkOutput("idle_wr_ready", int'(wr_ready), 1);
        checkOutput("idle_map_we", int'(map_we), 1);
        checkOutput("idle_char_we", int'(char_we), 0);
        checkOutput("idle_map_wr_addr", int'(map_wr_addr), 1234);
        checkOutput("idle_map_din", int'(map_din), 'h5C);
        @(negedge Clk);
        wr_valid = 1'b0;

        // Starvation: reads and a char write requested together and held
        @(negedge Clk);
        pix_x = 9'd0; pix_y = 9'd0; spr_x = 9'd100; spr_y = 9'd100; spr_frame = '0; spr_hflip = 1'b0;
        pix_valid = 1'b1;
        wr_valid = 1'b1; wr_sel = 1'b1; wr_addr = 19'h01123; wr_data = 8'hA5;
        grant_cyc = -1; map_pulses = 0; char_pulses = 0; wa = -1; wd = -1;
        forced_rdy = -1; sim_wr = -1; sim_pix = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 0) begin
                sim_wr  = int'(wr_ready);
                sim_pix = int'(pix_ready);
            end
            if (map_we) map_pulses++;
            if (char_we) begin
                char_pulses++;
                wa = int'(char_wr_addr);
                wd = int'(char_din);
            end
            if (wr_valid && wr_ready && grant_cyc < 0) begin
                grant_cyc  = c;
                forced_rdy = int'(pix_ready);
            end
            @(negedge Clk);
            if (grant_cyc >= 0 && wr_valid) begin
                wr_valid  = 1'b0;
                pix_valid = 1'b0;
            end
        end
        pix_valid = 1'b0;
        wr_valid  = 1'b0;
        checkOutput("simul_wr_ready", sim_wr, 0);
        checkOutput("simul_pix_ready", sim_pix, 1);
        checkOutput("starve_grant_within_16", int'(grant_cyc >= 0 && grant_cyc <= 16), 1);
        checkOutput("starve_forced_pix_ready", forced_rdy, 0);
        checkOutput("starve_char_we_pulses", char_pulses, 1);
        checkOutput("starve_map_we_pulses", map_pulses, 0);
        checkOutput("starve_char_wr_addr", wa, 'h1123);
        checkOutput("starve_char_din", wd, 'hA5);

        // Backpressure: consumer stalls for 10 cycles
        out_ready = 1'b0;
        applyStimulus(115, 100, 100, 100, 0, 1'b0, gp, gm, gc, gl);
        checkOutput("bp_latency", gl, 3);
        checkOutput("bp_pix", gp, 'h5A);
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            #1;
            ok = int'(out_valid && out_pix == 8'h5A && !pix_ready);
            checkOutput($sformatf("bp_hold_%0d", c), ok, 1);
        end
        @(negedge Clk);
        out_ready = 1'b1;
        #1;
        transfers = int'(out_valid && out_ready);
        @(negedge Clk);
        #1;
        checkOutput("bp_after_out_valid", int'(out_valid), 0);
        checkOutput("bp_after_pix_ready", int'(pix_ready), 1);
        repeat (3) begin
            @(negedge Clk);
            #1;
            if (out_valid && out_ready) transfers++;
        end
        checkOutput("bp_transfers", transfers, 1);

        // Reset asserted while the request sits in WAIT
        @(negedge Clk);
        pix_x = 9'd0; pix_y = 9'd0; spr_x = 9'd100; spr_y = 9'd100; spr_frame = '0;
        pix_valid = 1'b1;
        @(negedge Clk);
        pix_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_pix_ready", int'(pix_ready), 0);
        @(negedge Clk);
        #1;
        checkOutput("midrst_out_valid_held", int'(out_valid), 0);
        checkOutput("midrst_pix_ready_held", int'(pix_ready), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1 checkOutput("midrst_release_pix_ready_low", int'(pix_ready), 0);
        @(negedge Clk);
        #1 checkOutput("midrst_release_pix_ready_high", int'(pix_ready), 1);
        spurious = 0;
        repeat (6) begin
            @(negedge Clk);
            #1;
            if (out_valid) spurious++;
        end
        checkOutput("midrst_dropped_pixel", spurious, 0);

        // Randomized requests around a random sprite position
        for (int i = 0; i < 40; i++) begin
            sx = int'($urandom_range(0, 319));
            sy = int'($urandom_range(0, 239));
            px = sx + int'($urandom_range(0, 24)) - 4;
            py = sy + int'($urandom_range(0, 24)) - 4;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            if (px > 511) px = 511;
            if (py > 511) py = 511;
            fr = int'($urandom_range(0, 31));
            hf = 1'($urandom);
            applyStimulus(px, py, sx, sy, fr, hf, gp, gm, gc, gl);
            checkOutput($sformatf("rnd%0d_pix", i), gp, ref_pix(px, py, sx, sy, fr, hf));
            checkOutput($sformatf("rnd%0d_map_addr", i), gm, ref_map_addr(px, py));
            gl = ref_char_idx(px, py, sx, sy, fr, hf);
            checkOutput($sformatf("rnd%0d_char_addr", i), gc, (gl < 0) ? 0 : gl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
